dr_alm_pipe: RTL
================

Name: dr_alm_pipe

Overview:
- Pipelined, parametrised successor to the combinational dynamic-range approximate logarithmic multiplier (DR-ALM).
- Adds a 3-stage pipeline with valid/ready handshake and backpressure.
- Truncation width t is selectable per transaction at runtime, and each transaction can be signed or unsigned.
- Sits between operand producers (e.g. MAC/conv datapaths) and accumulators in the approximate-arithmetic evaluation path.

Parameters:
- DWIDTH, 16, operand width in bits (≥ 4).
- TRUNC_MAX, 8, maximum truncation width t supported by the datapath (2 ≤ TRUNC_MAX ≤ DWIDTH).
- TW, $clog2(TRUNC_MAX+1), width of the runtime truncation-select port.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept an input this cycle.
- i_a  in  DWIDTH  operand A.
- i_b  in  DWIDTH  operand B.
- i_signed  in  1  1 = operands are two's complement; 0 = unsigned.
- i_trunc  in  TW  truncation width t for this transaction.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_z  out  2*DWIDTH  product; two's complement when that transaction's i_signed=1.
- o_busy  out  1  any pipeline stage holds a valid transaction.

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, o_valid = 0, o_z = 0, o_busy = 0. o_ready = 1 after reset.
- Handshake:
  - Input is accepted when i_valid && o_ready.
  - Output is transferred when o_valid && i_ready.
  - o_ready = i_ready || !o_valid. The whole pipeline advances when o_ready = 1; bubbles are not collapsed.
  - When stalled (o_valid && !i_ready), o_z and o_valid hold stable.
- Latency: exactly 3 cycles from acceptance to o_valid with no stall. Throughput is 1 result per cycle.
- i_signed and i_trunc are captured with the operands and travel with their transaction.
- Effective t = clamp(i_trunc, 2, TRUNC_MAX).
- S1 (register):
  - sign_a = i_signed & i_a[MSB]; same for sign_b.
  - abs = sign ? two's-complement negate : raw value, DWIDTH bits unsigned. The most negative value maps to 2^(DWIDTH-1).
  - zero flag = (i_a == 0 || i_b == 0).
  - sign_z = sign_a ^ sign_b.
- S2 (register):
  - k = index of the leading one of abs.
  - Normalise abs so its leading one is at bit DWIDTH-1.
  - xt = {top t-1 bits below the leading one, 1'b1}. xt is t bits wide, left-aligned in a TRUNC_MAX-bit field.
  - sum = xa_t + xb_t + 1 (t+1 bits); carry c = sum[t].
  - K = ka + kb + c; frac = sum[t-1:0].
- S3 (output register):
  - m = {1, frac} (t+1 bits).
  - mag = K ≥ t ? m << (K − t) : m >> (t − K).
  - o_z = zero ? 0 : (sign_z ? −mag : mag).
- Results fit in 2*DWIDTH bits for all inputs; no saturation is needed.
- Changing i_trunc between transactions takes effect only for the newly accepted transaction.
- i_valid with o_ready = 0: not accepted. The producer must hold the operands.
- Reset mid-operation: in-flight transactions are discarded and no partial output is produced.
- o_busy = OR of the S1, S2 and S3 valid bits.

Optional Feature:
- Macro DR_ALM_APPROX_SIGN_EN.
- When defined, signed mode uses the low-cost approximate sign handling:
  - abs = ~operand (one's complement) for negative operands.
  - Output = ~mag (bitwise invert) when sign_z = 1.
  - Zero-operand detection still uses the raw input.
- When undefined, exact two's-complement negation is used as described above.
- Unsigned mode is identical in both builds.

Test Plan:
- DWIDTH=16, t=6, signed: a=3, b=5 → o_z=14 exactly 3 cycles after acceptance. a=−3, b=5 → −14. a=1, b=1 → 1.
- Zero operand: a=0, b=−1234 (and a=77, b=0) → o_z=0 for any t.
- Extremes, t=6: signed a=b=−32768 → 1124073472. Unsigned a=b=65535 → 4261412864.
- Runtime t: i_trunc=0 → behaves as t=2; i_trunc=15 → behaves as TRUNC_MAX. Back-to-back transactions with differing t each match the model.
- Backpressure: stream 20 random transactions while i_ready toggles pseudo-randomly. Check against the model: no drops or duplicates, o_z stable while stalled, ordering preserved.
- Assert i_rst_n low with 3 transactions in flight → o_valid=0 and o_busy=0 immediately, with no stale output after release. Under DR_ALM_APPROX_SIGN_EN, a=−3, b=5, t=6 → −11.

Source files
------------

// File: rtl/dr_alm_pipe.sv
// dr_alm_pipe: 3-stage pipelined dynamic-range approximate log multiplier.
// Valid/ready handshake; the whole pipe advances when o_ready is high.
// Truncation width t and signedness are captured per transaction.
// Optional build macro: DR_ALM_APPROX_SIGN_EN selects one's-complement
// sign handling (cheaper, approximate) in signed mode.
module dr_alm_pipe #(
  parameter int DWIDTH    = 16,
  parameter int TRUNC_MAX = 8,
  parameter int TW        = $clog2(TRUNC_MAX + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DWIDTH-1:0]     i_a,
  input  logic [DWIDTH-1:0]     i_b,
  input  logic                  i_signed,
  input  logic [TW-1:0]         i_trunc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*DWIDTH-1:0]   o_z,
  output logic                  o_busy
);

  localparam int ZW = 2 * DWIDTH;
  localparam int KW = $clog2(2 * DWIDTH);
  localparam int LW = $clog2(DWIDTH);
  localparam int SW = TRUNC_MAX + 1;

  // Position of the leading one; an all-zero value reports 0.
  function automatic logic [LW-1:0] f_lead(input logic [DWIDTH-1:0] v);
    f_lead = '0;
    for (int i = 0; i < DWIDTH; i++)
      if (v[i]) f_lead = LW'(i);
  endfunction

  // Top t-1 fraction bits plus a trailing 1, left-aligned in TRUNC_MAX bits.
  function automatic logic [TRUNC_MAX-1:0] f_xt(input logic [DWIDTH-1:0] v,
                                                input logic [LW-1:0]     k,
                                                input logic [TW-1:0]     t);
    logic [DWIDTH-1:0]    norm;
    logic [TRUNC_MAX-1:0] fld;
    logic [TW-1:0]        pos;
    norm = v << (LW'(DWIDTH - 1) - k);
    pos  = TW'(TRUNC_MAX) - t;
    fld  = '0;
    for (int i = 1; i < TRUNC_MAX; i++)
      if (i > TRUNC_MAX - int'(t)) fld[i] = norm[DWIDTH-1-TRUNC_MAX+i];
    fld = fld | (TRUNC_MAX'(1) << pos);
    return fld;
  endfunction

  logic                 r_s1_v, r_s2_v, r_s3_v;
  logic [DWIDTH-1:0]    r_s1_abs_a, r_s1_abs_b;
  logic                 r_s1_zero, r_s1_sz;
  logic [TW-1:0]        r_s1_t;
  logic [TRUNC_MAX-1:0] r_s2_frac;
  logic [KW-1:0]        r_s2_k;
  logic                 r_s2_zero, r_s2_sz;
  logic [ZW-1:0]        r_z;

  logic                 w_adv;
  logic [TW-1:0]        w_t_eff;
  logic                 w_sign_a, w_sign_b;
  logic [DWIDTH-1:0]    w_abs_a, w_abs_b;
  logic [LW-1:0]        w_ka, w_kb;
  logic [TRUNC_MAX-1:0] w_xa, w_xb;
  logic [SW-1:0]        w_sum;
  logic [KW-1:0]        w_k;
  logic [ZW-1:0]        w_m, w_mag, w_z;

  assign o_ready = i_ready | ~r_s3_v;
  assign w_adv   = o_ready;
  assign o_valid = r_s3_v;
  assign o_z     = r_z;
  assign o_busy  = r_s1_v | r_s2_v | r_s3_v;

  // S1 combinational: clamp t, take magnitudes.
  always_comb begin
    w_t_eff = i_trunc;
    if (i_trunc < TW'(2))              w_t_eff = TW'(2);
    else if (i_trunc > TW'(TRUNC_MAX)) w_t_eff = TW'(TRUNC_MAX);
    w_sign_a = i_signed & i_a[DWIDTH-1];
    w_sign_b = i_signed & i_b[DWIDTH-1];
`ifdef DR_ALM_APPROX_SIGN_EN
    w_abs_a = w_sign_a ? ~i_a : i_a;
    w_abs_b = w_sign_b ? ~i_b : i_b;
`else
    w_abs_a = w_sign_a ? (~i_a + DWIDTH'(1)) : i_a;
    w_abs_b = w_sign_b ? (~i_b + DWIDTH'(1)) : i_b;
`endif
  end

  // S2 combinational: leading-one detect, truncated mantissas, log-domain add.
  always_comb begin
    w_ka  = f_lead(r_s1_abs_a);
    w_kb  = f_lead(r_s1_abs_b);
    w_xa  = f_xt(r_s1_abs_a, w_ka, r_s1_t);
    w_xb  = f_xt(r_s1_abs_b, w_kb, r_s1_t);
    w_sum = {1'b0, w_xa} + {1'b0, w_xb} + (SW'(1) << (TW'(TRUNC_MAX) - r_s1_t));
    w_k   = KW'(w_ka) + KW'(w_kb) + KW'(w_sum[TRUNC_MAX]);
  end

  // S3 combinational: antilog. Fraction is left-aligned, so shift against TRUNC_MAX.
  always_comb begin
    w_m = ZW'({1'b1, r_s2_frac});
    if (r_s2_k >= KW'(TRUNC_MAX)) w_mag = w_m << (r_s2_k - KW'(TRUNC_MAX));
    else                          w_mag = w_m >> (KW'(TRUNC_MAX) - r_s2_k);
    w_z = w_mag;
`ifdef DR_ALM_APPROX_SIGN_EN
    if (r_s2_sz) w_z = ~w_mag;
`else
    if (r_s2_sz) w_z = ~w_mag + ZW'(1);
`endif
    if (r_s2_zero) w_z = '0;
  end

  // Pipeline registers; every stage moves together whenever the output can drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s3_v     <= 1'b0;
      r_s1_abs_a <= '0;
      r_s1_abs_b <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_sz    <= 1'b0;
      r_s1_t     <= TW'(2);
      r_s2_frac  <= '0;
      r_s2_k     <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_sz    <= 1'b0;
      r_z        <= '0;
    end else if (w_adv) begin
      r_s1_v     <= i_valid;
      r_s1_abs_a <= w_abs_a;
      r_s1_abs_b <= w_abs_b;
      r_s1_zero  <= (i_a == '0) || (i_b == '0);
      r_s1_sz    <= w_sign_a ^ w_sign_b;
      r_s1_t     <= w_t_eff;
      r_s2_v     <= r_s1_v;
      r_s2_frac  <= w_sum[TRUNC_MAX-1:0];
      r_s2_k     <= w_k;
      r_s2_zero  <= r_s1_zero;
      r_s2_sz    <= r_s1_sz;
      r_s3_v     <= r_s2_v;
      r_z        <= w_z;
    end
  end

endmodule
